// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus block-counter tweakey lane.
// Holds the domain separator bytes, the default feedback polynomials,
// the lane width helper and the stepping FSM state type.
package romulus_pkg;

    // Domain separator bytes placed below the counter bytes in the lane
    localparam logic [7:0] DOM_AD  = 8'h08;
    localparam logic [7:0] DOM_MSG = 8'h04;
    localparam logic [7:0] DOM_TAG = 8'h15;

    // Feedback masks: x^56+x^7+x^4+x^2+1 and x^8+x^4+x^3+x^2+1 (8-bit test counter)
    localparam logic [55:0] POLY_56 = 56'h95;
    localparam logic [7:0]  POLY_8  = 8'h1D;

    // Lane width: 64 bits for the half tweakey, 128 bits for the full one
    function automatic int tkz_w(input int full_tk);
        return 64 + 64 * ((full_tk != 0) ? 1 : 0);
    endfunction

    // Stepping FSM: a 2-step request spends its second cycle in ST_STEP2
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STEP2 = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/romulus_lfsr_step.sv
// Combinational single LFSR step: shift left, fold POLY back in when the
// MSB falls off the top.
module romulus_lfsr_step #(
    parameter int               CNT_W = 56,
    parameter logic [CNT_W-1:0] POLY  = CNT_W'(56'h95)
) (
    input  logic [CNT_W-1:0] cur,
    output logic [CNT_W-1:0] nxt
);

    assign nxt = {cur[CNT_W-2:0], 1'b0} ^ (cur[CNT_W-1] ? POLY : '0);

endmodule

// File: rtl/romulus_cnt_unit.sv
// LFSR block counter plus domain byte forming the TK3 counter lane.
// Advances 1 or 2 LFSR steps per valid/ready request, flags (sticky) when
// the counter returns to its seed, and emits the byte-reversed lane.
// Optional checkpoint/restore is built when ROMULUS_CNT_CHECKPOINT_EN is
// defined; without it save/restore are ignored.
module romulus_cnt_unit
    import romulus_pkg::*;
#(
    parameter int               CNT_W   = 56,
    parameter logic [CNT_W-1:0] POLY    = CNT_W'(POLY_56),
    parameter int               FULL_TK = 0,
    localparam int              TKZ_W   = tkz_w(FULL_TK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             dom_load,
    input  logic [7:0]       domain,
    input  logic             step_valid,
    input  logic [1:0]       step_n,
    output logic             step_ready,
    input  logic             save,
    input  logic             restore,
    output logic [CNT_W-1:0] counter,
    output logic [TKZ_W-1:0] tkz,
    output logic             exhausted
);

    localparam logic [CNT_W-1:0] SEED = CNT_W'(1);

    generate
        if ((CNT_W % 8) != 0 || CNT_W < 8 || CNT_W > 120 || (CNT_W + 8) > TKZ_W) begin : g_bad_cfg
            $error("romulus_cnt_unit: unsupported CNT_W/FULL_TK combination");
        end
    endgenerate

    cnt_state_t       state_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [7:0]       domain_reg;
    logic             exhausted_reg;
    logic [CNT_W-1:0] step_next;
    logic             accept;
    logic             do_step;
    logic             do_restore;

    // Single shared step function: both FSM states advance from counter_reg
    romulus_lfsr_step #(
        .CNT_W (CNT_W),
        .POLY  (POLY)
    ) u_step (
        .cur (counter_reg),
        .nxt (step_next)
    );

`ifdef ROMULUS_CNT_CHECKPOINT_EN
    logic [CNT_W-1:0] ckpt_reg;
    logic             ckpt_exh_reg;

    assign do_restore = restore;

    // Checkpoint snapshot of counter and exhaustion flag (pre-update values)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckpt_reg     <= SEED;
            ckpt_exh_reg <= 1'b0;
        end else if (init) begin
            ckpt_reg     <= SEED;
            ckpt_exh_reg <= 1'b0;
        end else if (save) begin
            ckpt_reg     <= counter_reg;
            ckpt_exh_reg <= exhausted_reg;
        end
    end
`else
    // Checkpointing not built: save/restore are accepted but have no effect
    logic unused_ckpt_in;
    assign unused_ckpt_in = &{1'b0, save, restore};
    assign do_restore     = 1'b0;
`endif

    assign step_ready = (state_reg == ST_IDLE);
    assign accept     = step_valid & step_ready;
    // step_n = 0 completes the handshake without moving anything
    assign do_step    = (accept && (step_n != 2'd0)) || (state_reg == ST_STEP2);

    // Counter, exhaustion flag and FSM: init > restore > step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg   <= SEED;
            exhausted_reg <= 1'b0;
            state_reg     <= ST_IDLE;
        end else if (init) begin
            counter_reg   <= SEED;
            exhausted_reg <= 1'b0;
            state_reg     <= ST_IDLE;
        end else if (do_restore) begin
`ifdef ROMULUS_CNT_CHECKPOINT_EN
            counter_reg   <= ckpt_reg;
            exhausted_reg <= ckpt_exh_reg;
`endif
            state_reg     <= ST_IDLE;
        end else if (do_step) begin
            // Once the period is used up the counter freezes but the
            // handshake timing stays the same
            if (!exhausted_reg) begin
                counter_reg <= step_next;
                if (step_next == SEED) begin
                    exhausted_reg <= 1'b1;
                end
            end
            if (state_reg == ST_IDLE && step_n[1]) begin
                state_reg <= ST_STEP2;
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // Domain byte register, independent of stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            domain_reg <= 8'h00;
        end else if (init) begin
            domain_reg <= 8'h00;
        end else if (dom_load) begin
            domain_reg <= domain;
        end
    end

    // Lane assembly: counter bytes reversed at the top, domain below, zero pad
    always_comb begin
        tkz = '0;
        for (int k = 0; k < CNT_W / 8; k++) begin
            tkz[TKZ_W-1-8*k -: 8] = counter_reg[8*k +: 8];
        end
        tkz[TKZ_W-1-CNT_W -: 8] = domain_reg;
    end

    assign counter   = counter_reg;
    assign exhausted = exhausted_reg;

endmodule
